// File: rtl/bp_cache_req_responder.sv
// rtl/bp_cache_req_responder.sv - cache miss / uncached request service engine
//
// Takes one miss or uncached request from a write-through cache, fetches the
// block (or single word) over a command/response memory channel and installs
// the result through tag, data and stat packets, ending with a one-cycle
// completion pulse. Victims are always clean, so there is no writeback path.
//
// Ports:
//   clk_i, reset_i            clock; asynchronous active-low reset
//   cache_req_*               request handshake, type, addr, size, data, metadata
//   cache_req_complete_o      one-cycle pulse when the request is fully serviced
//   mem_cmd_*                 memory command (read/write, addr, log2 size, data)
//   mem_resp_*                memory response beats, consumed with yumi
//   data_mem_pkt_*            block (or zero-extended uncached word) install
//   tag_mem_pkt_*             tag + coherence state install
//   stat_mem_pkt_*            MRU / dirty-clear update

module bp_cache_req_responder #(
  parameter int paddr_width_p    = 40,
  parameter int sets_p           = 64,
  parameter int assoc_p          = 8,
  parameter int block_width_p    = 512,
  parameter int mem_data_width_p = 64,
  parameter int ptag_width_p     = paddr_width_p - $clog2(sets_p) - $clog2(block_width_p/8),
  localparam int index_w  = $clog2(sets_p),
  localparam int way_w    = $clog2(assoc_p),
  localparam int offset_w = $clog2(block_width_p/8),
  localparam int beats_lp = block_width_p/mem_data_width_p,
  localparam int beat_w   = $clog2(beats_lp)
) (
  input  logic                        clk_i,
  input  logic                        reset_i,

  input  logic                        cache_req_v_i,
  output logic                        cache_req_ready_o,
  input  logic [1:0]                  cache_req_type_i,
  input  logic [paddr_width_p-1:0]    cache_req_addr_i,
  input  logic [1:0]                  cache_req_size_i,
  input  logic [63:0]                 cache_req_data_i,
  input  logic                        cache_req_metadata_v_i,
  input  logic [way_w-1:0]            cache_req_metadata_way_i,
  output logic                        cache_req_complete_o,

  output logic                        mem_cmd_v_o,
  input  logic                        mem_cmd_ready_i,
  output logic                        mem_cmd_write_o,
  output logic [paddr_width_p-1:0]    mem_cmd_addr_o,
  // 3 bits so that a full-block size (log2 of 64 bytes = 6) is representable
  output logic [2:0]                  mem_cmd_size_o,
  output logic [63:0]                 mem_cmd_data_o,

  input  logic                        mem_resp_v_i,
  output logic                        mem_resp_yumi_o,
  input  logic [mem_data_width_p-1:0] mem_resp_data_i,

  output logic                        data_mem_pkt_v_o,
  input  logic                        data_mem_pkt_ready_i,
  output logic                        data_mem_pkt_uncached_o,
  output logic [index_w-1:0]          data_mem_pkt_index_o,
  output logic [way_w-1:0]            data_mem_pkt_way_o,
  output logic [block_width_p-1:0]    data_mem_pkt_data_o,

  output logic                        tag_mem_pkt_v_o,
  input  logic                        tag_mem_pkt_ready_i,
  output logic [index_w-1:0]          tag_mem_pkt_index_o,
  output logic [way_w-1:0]            tag_mem_pkt_way_o,
  output logic [ptag_width_p-1:0]     tag_mem_pkt_tag_o,
  output logic [1:0]                  tag_mem_pkt_state_o,

  output logic                        stat_mem_pkt_v_o,
  input  logic                        stat_mem_pkt_ready_i,
  output logic [index_w-1:0]          stat_mem_pkt_index_o,
  output logic [way_w-1:0]            stat_mem_pkt_way_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_META, S_CMD, S_RESP, S_TAG, S_DATA, S_STAT, S_UC_DATA, S_DONE
  } state_e;

  state_e                       state_r, state_n;
  logic                         ready_r, cmd_v_r, tag_v_r, data_v_r, stat_v_r, complete_r;
  logic [beat_w-1:0]            beat_r;

  logic [1:0]                   req_type_r;
  logic [paddr_width_p-1:0]     req_addr_r;
  logic [1:0]                   req_size_r;
  logic [63:0]                  req_data_r;
  logic [way_w-1:0]             way_r;
  logic [block_width_p-1:0]     block_r;

  logic req_fire, resp_fire, beat_last, uncached;

  assign uncached  = req_type_r[1];
  assign req_fire  = ready_r & cache_req_v_i;
  assign resp_fire = (state_r == S_RESP) & mem_resp_v_i;
  assign beat_last = (beat_r == beat_w'(beats_lp - 1));

  always_comb begin
    state_n = state_r;
    case (state_r)
      S_IDLE:    if (req_fire)
                   // Metadata seen with the request lets a miss skip META
                   state_n = (cache_req_type_i[1] | cache_req_metadata_v_i) ? S_CMD : S_META;
      S_META:    if (cache_req_metadata_v_i) state_n = S_CMD;
      S_CMD:     if (mem_cmd_ready_i)        state_n = S_RESP;
      S_RESP:    if (mem_resp_v_i) begin
                   if (uncached)       state_n = req_type_r[0] ? S_DONE : S_UC_DATA;
                   else if (beat_last) state_n = S_TAG;
                 end
      S_TAG:     if (tag_mem_pkt_ready_i)    state_n = S_DATA;
      S_DATA:    if (data_mem_pkt_ready_i)   state_n = S_STAT;
      S_STAT:    if (stat_mem_pkt_ready_i)   state_n = S_DONE;
      S_UC_DATA: if (data_mem_pkt_ready_i)   state_n = S_DONE;
      S_DONE:                                state_n = S_IDLE;
      default:                               state_n = S_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they track the
  // state register exactly and never depend combinationally on a ready.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r    <= S_IDLE;
      ready_r    <= 1'b0;
      cmd_v_r    <= 1'b0;
      tag_v_r    <= 1'b0;
      data_v_r   <= 1'b0;
      stat_v_r   <= 1'b0;
      complete_r <= 1'b0;
      beat_r     <= '0;
    end else begin
      state_r    <= state_n;
      ready_r    <= (state_n == S_IDLE);
      cmd_v_r    <= (state_n == S_CMD);
      tag_v_r    <= (state_n == S_TAG);
      data_v_r   <= (state_n == S_DATA) | (state_n == S_UC_DATA);
      stat_v_r   <= (state_n == S_STAT);
      complete_r <= (state_n == S_DONE);
      if (resp_fire && !uncached)
        beat_r <= beat_last ? '0 : beat_r + 1'b1;
    end
  end

  // Request payload and assembled block; contents are don't-care out of reset.
  always_ff @(posedge clk_i) begin
    if (req_fire) begin
      req_type_r <= cache_req_type_i;
      req_addr_r <= cache_req_addr_i;
      req_size_r <= cache_req_size_i;
      req_data_r <= cache_req_data_i;
    end
    if ((req_fire && !cache_req_type_i[1] && cache_req_metadata_v_i) ||
        (state_r == S_META && cache_req_metadata_v_i))
      way_r <= cache_req_metadata_way_i;
    if (resp_fire) begin
      if (uncached)
        block_r <= {{(block_width_p-mem_data_width_p){1'b0}}, mem_resp_data_i};
      else
        for (int k = 0; k < beats_lp; k++)
          if (beat_r == beat_w'(k))
            block_r[k*mem_data_width_p +: mem_data_width_p] <= mem_resp_data_i;
    end
  end

  assign cache_req_ready_o    = ready_r;
  assign cache_req_complete_o = complete_r;

  assign mem_cmd_v_o     = cmd_v_r;
  assign mem_cmd_write_o = (req_type_r == 2'd3);
  assign mem_cmd_addr_o  = uncached ? req_addr_r
                                    : {req_addr_r[paddr_width_p-1:offset_w], {offset_w{1'b0}}};
  assign mem_cmd_size_o  = uncached ? {1'b0, req_size_r} : 3'(offset_w);
  assign mem_cmd_data_o  = req_data_r;

  assign mem_resp_yumi_o = resp_fire;

  assign data_mem_pkt_v_o        = data_v_r;
  assign data_mem_pkt_uncached_o = uncached;
  assign data_mem_pkt_index_o    = req_addr_r[offset_w +: index_w];
  assign data_mem_pkt_way_o      = way_r;
  assign data_mem_pkt_data_o     = block_r;

  assign tag_mem_pkt_v_o     = tag_v_r;
  assign tag_mem_pkt_index_o = req_addr_r[offset_w +: index_w];
  assign tag_mem_pkt_way_o   = way_r;
  assign tag_mem_pkt_tag_o   = req_addr_r[paddr_width_p-1 -: ptag_width_p];
  // Miss store installs exclusive, miss load installs shared
  assign tag_mem_pkt_state_o = (req_type_r == 2'd1) ? 2'd2 : 2'd1;

  assign stat_mem_pkt_v_o     = stat_v_r;
  assign stat_mem_pkt_index_o = req_addr_r[offset_w +: index_w];
  assign stat_mem_pkt_way_o   = way_r;

endmodule

// File: tb/tb_bp_cache_req_responder.sv
// tb/tb_bp_cache_req_responder.sv - scoreboard bench for bp_cache_req_responder
module tb_bp_cache_req_responder;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic         reset_i;
  logic         cache_req_v_i, cache_req_ready_o;
  logic [1:0]   cache_req_type_i;
  logic [39:0]  cache_req_addr_i;
  logic [1:0]   cache_req_size_i;
  logic [63:0]  cache_req_data_i;
  logic         cache_req_metadata_v_i;
  logic [2:0]   cache_req_metadata_way_i;
  logic         cache_req_complete_o;
  logic         mem_cmd_v_o, mem_cmd_ready_i, mem_cmd_write_o;
  logic [39:0]  mem_cmd_addr_o;
  logic [2:0]   mem_cmd_size_o;
  logic [63:0]  mem_cmd_data_o;
  logic         mem_resp_v_i, mem_resp_yumi_o;
  logic [63:0]  mem_resp_data_i;
  logic         data_mem_pkt_v_o, data_mem_pkt_ready_i, data_mem_pkt_uncached_o;
  logic [5:0]   data_mem_pkt_index_o;
  logic [2:0]   data_mem_pkt_way_o;
  logic [511:0] data_mem_pkt_data_o;
  logic         tag_mem_pkt_v_o, tag_mem_pkt_ready_i;
  logic [5:0]   tag_mem_pkt_index_o;
  logic [2:0]   tag_mem_pkt_way_o;
  logic [27:0]  tag_mem_pkt_tag_o;
  logic [1:0]   tag_mem_pkt_state_o;
  logic         stat_mem_pkt_v_o, stat_mem_pkt_ready_i;
  logic [5:0]   stat_mem_pkt_index_o;
  logic [2:0]   stat_mem_pkt_way_o;

  bp_cache_req_responder dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .cache_req_v_i(cache_req_v_i), .cache_req_ready_o(cache_req_ready_o),
    .cache_req_type_i(cache_req_type_i), .cache_req_addr_i(cache_req_addr_i),
    .cache_req_size_i(cache_req_size_i), .cache_req_data_i(cache_req_data_i),
    .cache_req_metadata_v_i(cache_req_metadata_v_i),
    .cache_req_metadata_way_i(cache_req_metadata_way_i),
    .cache_req_complete_o(cache_req_complete_o),
    .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_ready_i(mem_cmd_ready_i),
    .mem_cmd_write_o(mem_cmd_write_o), .mem_cmd_addr_o(mem_cmd_addr_o),
    .mem_cmd_size_o(mem_cmd_size_o), .mem_cmd_data_o(mem_cmd_data_o),
    .mem_resp_v_i(mem_resp_v_i), .mem_resp_yumi_o(mem_resp_yumi_o),
    .mem_resp_data_i(mem_resp_data_i),
    .data_mem_pkt_v_o(data_mem_pkt_v_o), .data_mem_pkt_ready_i(data_mem_pkt_ready_i),
    .data_mem_pkt_uncached_o(data_mem_pkt_uncached_o),
    .data_mem_pkt_index_o(data_mem_pkt_index_o), .data_mem_pkt_way_o(data_mem_pkt_way_o),
    .data_mem_pkt_data_o(data_mem_pkt_data_o),
    .tag_mem_pkt_v_o(tag_mem_pkt_v_o), .tag_mem_pkt_ready_i(tag_mem_pkt_ready_i),
    .tag_mem_pkt_index_o(tag_mem_pkt_index_o), .tag_mem_pkt_way_o(tag_mem_pkt_way_o),
    .tag_mem_pkt_tag_o(tag_mem_pkt_tag_o), .tag_mem_pkt_state_o(tag_mem_pkt_state_o),
    .stat_mem_pkt_v_o(stat_mem_pkt_v_o), .stat_mem_pkt_ready_i(stat_mem_pkt_ready_i),
    .stat_mem_pkt_index_o(stat_mem_pkt_index_o), .stat_mem_pkt_way_o(stat_mem_pkt_way_o)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct { logic wr; logic [39:0] addr; logic [2:0] size; logic [63:0] data; } cmd_t;
  typedef struct { logic [5:0] idx; logic [2:0] way; logic [27:0] tag; logic [1:0] st; } tag_t;
  typedef struct { logic uc; logic [5:0] idx; logic [2:0] way; logic [511:0] data; } dat_t;
  typedef struct { logic [5:0] idx; logic [2:0] way; } stat_t;

  cmd_t  cmd_q[$];
  tag_t  tag_q[$];
  dat_t  dat_q[$];
  stat_t stat_q[$];
  int    cpl_q[$];

  // ---------------- monitor: pops expectations whenever the DUT hands something off
  int     req_cyc = 0;
  int     n_tag = 0, n_data = 0, n_stat = 0, n_cpl = 0;
  cmd_t   ec, last_cmd;
  tag_t   et, last_tag;
  dat_t   ed, last_dat;
  stat_t  es;
  int     el;

  always @(negedge clk_i) if (reset_i) begin
    if (cache_req_v_i && cache_req_ready_o) req_cyc = cyc;
    if (mem_cmd_v_o && mem_cmd_ready_i) begin
      last_cmd.wr = mem_cmd_write_o; last_cmd.addr = mem_cmd_addr_o;
      last_cmd.size = mem_cmd_size_o; last_cmd.data = mem_cmd_data_o;
      check("cmd_expected", cmd_q.size() > 0, 1'b1);
      if (cmd_q.size() > 0) begin
        ec = cmd_q.pop_front();
        check("cmd_write", mem_cmd_write_o, ec.wr);
        check("cmd_addr", mem_cmd_addr_o, ec.addr);
        check("cmd_size", mem_cmd_size_o, ec.size);
        if (ec.wr) check("cmd_data", mem_cmd_data_o, ec.data);
      end
    end
    if (tag_mem_pkt_v_o && tag_mem_pkt_ready_i) begin
      n_tag++;
      last_tag.idx = tag_mem_pkt_index_o; last_tag.way = tag_mem_pkt_way_o;
      last_tag.tag = tag_mem_pkt_tag_o;   last_tag.st  = tag_mem_pkt_state_o;
      check("tag_expected", tag_q.size() > 0, 1'b1);
      if (tag_q.size() > 0) begin
        et = tag_q.pop_front();
        check("tag_index", tag_mem_pkt_index_o, et.idx);
        check("tag_way", tag_mem_pkt_way_o, et.way);
        check("tag_tag", tag_mem_pkt_tag_o, et.tag);
        check("tag_state", tag_mem_pkt_state_o, et.st);
      end
    end
    if (data_mem_pkt_v_o && data_mem_pkt_ready_i) begin
      n_data++;
      last_dat.uc = data_mem_pkt_uncached_o; last_dat.data = data_mem_pkt_data_o;
      check("data_expected", dat_q.size() > 0, 1'b1);
      if (dat_q.size() > 0) begin
        ed = dat_q.pop_front();
        check("data_uncached", data_mem_pkt_uncached_o, ed.uc);
        check("data_block", data_mem_pkt_data_o, ed.data);
        if (!ed.uc) begin
          check("data_index", data_mem_pkt_index_o, ed.idx);
          check("data_way", data_mem_pkt_way_o, ed.way);
        end
      end
    end
    if (stat_mem_pkt_v_o && stat_mem_pkt_ready_i) begin
      n_stat++;
      check("stat_expected", stat_q.size() > 0, 1'b1);
      if (stat_q.size() > 0) begin
        es = stat_q.pop_front();
        check("stat_index", stat_mem_pkt_index_o, es.idx);
        check("stat_way", stat_mem_pkt_way_o, es.way);
      end
    end
    if (cache_req_complete_o) begin
      n_cpl++;
      check("cpl_expected", cpl_q.size() > 0, 1'b1);
      if (cpl_q.size() > 0) begin
        el = cpl_q.pop_front();
        if (el >= 0) check("cpl_latency", cyc - req_cyc, el);
      end
    end
  end

  // ---------------- driver helpers
  logic [63:0] beats [8];

  function automatic logic sig(input int w);
    case (w)
      0: return cache_req_ready_o;
      1: return mem_cmd_v_o;
      2: return tag_mem_pkt_v_o;
      3: return data_mem_pkt_v_o;
      4: return stat_mem_pkt_v_o;
      default: return cache_req_complete_o;
    endcase
  endfunction

  function automatic logic [639:0] snap(input int w);
    case (w)
      1: return {mem_cmd_v_o, mem_cmd_write_o, mem_cmd_addr_o, mem_cmd_size_o, mem_cmd_data_o};
      2: return {tag_mem_pkt_v_o, tag_mem_pkt_index_o, tag_mem_pkt_way_o,
                 tag_mem_pkt_tag_o, tag_mem_pkt_state_o};
      3: return {data_mem_pkt_v_o, data_mem_pkt_uncached_o, data_mem_pkt_data_o};
      default: return {stat_mem_pkt_v_o, stat_mem_pkt_index_o, stat_mem_pkt_way_o};
    endcase
  endfunction

  task automatic set_ready(input int w, input logic v);
    case (w)
      1: mem_cmd_ready_i = v;
      2: tag_mem_pkt_ready_i = v;
      3: data_mem_pkt_ready_i = v;
      default: stat_mem_pkt_ready_i = v;
    endcase
  endtask

  task automatic wait_for(input int w, input string name);
    int t = 0;
    @(negedge clk_i);
    while (!sig(w) && t < 300) begin @(negedge clk_i); t++; end
    check(name, sig(w), 1'b1);
  endtask

  // Hold the ready of a presented handshake low, require a stable payload, then accept.
  task automatic hold_accept(input int w);
    logic [639:0] s;
    wait_for(w, "bp_valid_seen");
    s = snap(w);
    repeat (4) begin @(negedge clk_i); check("bp_hold_stable", snap(w), s); end
    @(posedge clk_i); #1; set_ready(w, 1'b1);
    @(posedge clk_i); #1; set_ready(w, 1'b0);
  endtask

  task automatic do_req(input logic [1:0] typ, input logic [39:0] addr, input logic [1:0] size,
                        input logic [63:0] data, input logic [2:0] way, input int d,
                        input bit bp, input int gap_max, input int abort_beats, input bit lat_chk);
    int nb, gsum;
    int gaps [8];
    logic [511:0] blk;
    cmd_t c; tag_t tg; dat_t dt; stat_t st;
    logic [5:0] idx;
    bit miss;
    miss = !typ[1];
    nb = miss ? 8 : 1;
    gsum = 0;
    for (int k = 0; k < 8; k++) begin
      gaps[k] = bp ? 1 + $urandom_range(0, 1) : (gap_max > 0 ? $urandom_range(0, gap_max) : 0);
      if (k < nb) gsum += gaps[k];
    end
    // reference model: block is the beats laid end to end, lowest beat first
    blk = '0;
    if (miss) for (int k = 0; k < 8; k++) blk = blk | ({448'b0, beats[k]} << (64 * k));
    else blk = {448'b0, beats[0]};
    idx = 6'((addr >> 6) % 64);
    c.wr = (typ == 2'd3);
    c.addr = miss ? (addr >> 6) << 6 : addr;
    c.size = miss ? 3'd6 : {1'b0, size};
    c.data = data;
    cmd_q.push_back(c);
    if (miss) begin
      tg.idx = idx; tg.way = way; tg.tag = 28'(addr >> 12); tg.st = (typ == 2'd1) ? 2'd2 : 2'd1;
      tag_q.push_back(tg);
      dt.uc = 1'b0; dt.idx = idx; dt.way = way; dt.data = blk;
      dat_q.push_back(dt);
      st.idx = idx; st.way = way;
      stat_q.push_back(st);
    end else if (typ == 2'd2) begin
      dt.uc = 1'b1; dt.idx = '0; dt.way = '0; dt.data = blk;
      dat_q.push_back(dt);
    end
    if (!lat_chk || bp) cpl_q.push_back(-1);
    else cpl_q.push_back(miss ? 13 + d + gsum : (typ == 2'd2 ? 4 + gsum : 3 + gsum));

    mem_cmd_ready_i = !bp;
    tag_mem_pkt_ready_i = !bp; data_mem_pkt_ready_i = !bp; stat_mem_pkt_ready_i = !bp;
    cache_req_v_i = 1'b1; cache_req_type_i = typ; cache_req_addr_i = addr;
    cache_req_size_i = size; cache_req_data_i = data;
    cache_req_metadata_v_i = (d == 0); cache_req_metadata_way_i = way;
    wait_for(0, "req_accept");
    @(posedge clk_i); #1;
    cache_req_v_i = 1'b0; cache_req_metadata_v_i = 1'b0;
    if (miss && d > 0) begin
      for (int i = 1; i < d; i++) begin
        @(negedge clk_i); check("no_cmd_before_meta", mem_cmd_v_o, 1'b0);
        @(posedge clk_i); #1;
      end
      cache_req_metadata_v_i = 1'b1; cache_req_metadata_way_i = way;
      @(negedge clk_i); check("no_cmd_before_meta", mem_cmd_v_o, 1'b0);
      @(posedge clk_i); #1;
      cache_req_metadata_v_i = 1'b0;
    end
    if (bp) hold_accept(1);
    else begin wait_for(1, "cmd_valid_seen"); @(posedge clk_i); #1; end
    for (int k = 0; k < nb; k++) begin
      mem_resp_v_i = 1'b0;
      repeat (gaps[k]) begin @(posedge clk_i); #1; end
      mem_resp_v_i = 1'b1; mem_resp_data_i = beats[k];
      // metadata outside META must not change the captured way
      if (k == 0 && miss) begin cache_req_metadata_v_i = 1'b1; cache_req_metadata_way_i = ~way; end
      @(posedge clk_i); #1;
      cache_req_metadata_v_i = 1'b0;
      if (abort_beats == k + 1) begin
        reset_i = 1'b0; mem_resp_v_i = 1'b1;
        #1;
        check("abort_cmd_v", mem_cmd_v_o, 1'b0);
        check("abort_tag_v", tag_mem_pkt_v_o, 1'b0);
        check("abort_data_v", data_mem_pkt_v_o, 1'b0);
        check("abort_stat_v", stat_mem_pkt_v_o, 1'b0);
        check("abort_complete", cache_req_complete_o, 1'b0);
        check("abort_ready", cache_req_ready_o, 1'b0);
        check("abort_yumi", mem_resp_yumi_o, 1'b0);
        mem_resp_v_i = 1'b0;
        tag_q.delete(); dat_q.delete(); stat_q.delete(); cpl_q.delete(); cmd_q.delete();
        @(posedge clk_i); @(posedge clk_i); #1;
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        check("ready_after_abort", cache_req_ready_o, 1'b1);
        return;
      end
    end
    mem_resp_v_i = 1'b0;
    if (bp) begin
      if (miss) begin hold_accept(2); hold_accept(3); hold_accept(4); end
      else if (typ == 2'd2) hold_accept(3);
    end
    wait_for(5, "complete_seen");
    @(posedge clk_i); #1;
    mem_cmd_ready_i = 1'b1;
    tag_mem_pkt_ready_i = 1'b1; data_mem_pkt_ready_i = 1'b1; stat_mem_pkt_ready_i = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, c0;
    logic [63:0] r;
    reset_i = 1'b0;
    cache_req_v_i = 0; cache_req_type_i = 0; cache_req_addr_i = 0; cache_req_size_i = 0;
    cache_req_data_i = 0; cache_req_metadata_v_i = 0; cache_req_metadata_way_i = 0;
    mem_cmd_ready_i = 1; mem_resp_v_i = 1; mem_resp_data_i = 0;
    data_mem_pkt_ready_i = 1; tag_mem_pkt_ready_i = 1; stat_mem_pkt_ready_i = 1;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ready", cache_req_ready_o, 1'b0);
    check("rst_cmd_v", mem_cmd_v_o, 1'b0);
    check("rst_tag_v", tag_mem_pkt_v_o, 1'b0);
    check("rst_data_v", data_mem_pkt_v_o, 1'b0);
    check("rst_stat_v", stat_mem_pkt_v_o, 1'b0);
    check("rst_complete", cache_req_complete_o, 1'b0);
    check("rst_yumi", mem_resp_yumi_o, 1'b0);
    mem_resp_v_i = 0;
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    check("ready_after_reset", cache_req_ready_o, 1'b1);

    // miss load, metadata with the request, beats 0..7
    for (int k = 0; k < 8; k++) beats[k] = 64'(k);
    do_req(2'd0, 40'h80_0001_2345, 2'd3, 64'h0, 3'd5, 0, 0, 0, -1, 1);
    check("t1_cmd_addr", last_cmd.addr, 40'h80_0001_2340);
    check("t1_cmd_write", last_cmd.wr, 1'b0);
    check("t1_cmd_size", last_cmd.size, 3'd6);
    check("t1_tag_index", last_tag.idx, 6'h0D);
    check("t1_tag_way", last_tag.way, 3'd5);
    check("t1_tag_tag", last_tag.tag, 28'h8000012);
    check("t1_tag_state", last_tag.st, 2'd1);
    check("t1_data_beat1", last_dat.data[127:64], 64'd1);

    // miss store, metadata 3 cycles late
    for (int k = 0; k < 8; k++) beats[k] = {$urandom, $urandom};
    do_req(2'd1, 40'h12_3456_7890, 2'd3, 64'h0, 3'd2, 3, 0, 0, -1, 1);
    check("t2_tag_state", last_tag.st, 2'd2);
    check("t2_tag_way", last_tag.way, 3'd2);

    // uncached load
    beats[0] = 64'hDEAD_BEEF;
    t0 = n_tag; t1 = n_stat;
    do_req(2'd2, 40'h00_0000_1004, 2'd2, 64'h0, 3'd0, 0, 0, 0, -1, 1);
    check("t3_uncached", last_dat.uc, 1'b1);
    check("t3_data", last_dat.data, 512'hDEAD_BEEF);
    check("t3_no_tag", n_tag - t0, 0);
    check("t3_no_stat", n_stat - t1, 0);

    // uncached store
    beats[0] = 64'h0;
    t0 = n_data;
    do_req(2'd3, 40'h00_0000_2001, 2'd0, 64'h55, 3'd0, 0, 0, 0, -1, 1);
    check("t4_cmd_write", last_cmd.wr, 1'b1);
    check("t4_cmd_data", last_cmd.data, 64'h55);
    check("t4_cmd_size", last_cmd.size, 3'd0);
    check("t4_no_data_pkt", n_data - t0, 0);

    // backpressure on every handshake plus response gaps
    for (int k = 0; k < 8; k++) beats[k] = {$urandom, $urandom};
    c0 = n_cpl;
    do_req(2'd0, 40'hAB_CDEF_0123, 2'd3, 64'h0, 3'd7, 0, 1, 2, -1, 0);
    check("t5_one_complete", n_cpl - c0, 1);
    beats[0] = {$urandom, $urandom};
    do_req(2'd2, 40'h01_0000_0008, 2'd3, 64'h0, 3'd0, 0, 1, 2, -1, 0);

    // reset after 3 beats, then a fresh miss
    for (int k = 0; k < 8; k++) beats[k] = {$urandom, $urandom};
    c0 = n_cpl;
    do_req(2'd0, 40'h55_5555_5555, 2'd3, 64'h0, 3'd4, 0, 0, 0, 3, 0);
    check("t6_no_complete_on_abort", n_cpl - c0, 0);
    for (int k = 0; k < 8; k++) beats[k] = {$urandom, $urandom};
    do_req(2'd0, 40'h33_3333_3333, 2'd3, 64'h0, 3'd6, 0, 0, 0, -1, 1);

    // randomized mix
    for (int n = 0; n < 30; n++) begin
      logic [1:0] typ;
      int d;
      typ = 2'($urandom_range(0, 3));
      r = {$urandom, $urandom};
      for (int k = 0; k < 8; k++) beats[k] = {$urandom, $urandom};
      d = typ[1] ? 0 : $urandom_range(0, 3);
      do_req(typ, r[39:0], 2'($urandom_range(0, 3)), {$urandom, $urandom},
             3'($urandom_range(0, 7)), d, 0, 2, -1, 1);
    end

    repeat (3) @(posedge clk_i);
    #1;
    check("end_cmd_q_empty", cmd_q.size(), 0);
    check("end_tag_q_empty", tag_q.size(), 0);
    check("end_dat_q_empty", dat_q.size(), 0);
    check("end_stat_q_empty", stat_q.size(), 0);
    check("end_cpl_q_empty", cpl_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
